// File: rtl/udma_spim_cmd_queue.sv
// Command-word FIFO between the uDMA command channel and the SPI master.
// EOT words are popped internally and reported on eot_o instead of forwarded.
module udma_spim_cmd_queue #(
   parameter int DEPTH     = 4,
   parameter int LOG_DEPTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic [31:0]          cmd_data_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   output logic [31:0]          udma_cmd_o,
   output logic                 udma_cmd_valid_o,
   input  logic                 udma_cmd_ready_i,
   output logic                 eot_o,
   output logic [LOG_DEPTH:0]   fill_o,
   output logic [15:0]          cmd_count_o
);

   localparam logic [3:0] OP_EOT = 4'b1001;

   logic [31:0]        mem_q [DEPTH];
   logic [31:0]        mem_d [DEPTH];
   logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               eot_q, eot_d;
   logic [31:0]        last_q, last_d;

   logic               full;
   logic               empty;
   logic [31:0]        head;
   logic               head_eot;
   logic               push;
   logic               fwd_pop;
   logic               eot_pop;

   assign full  = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                  (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign head     = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
   assign head_eot = (head[31:28] == OP_EOT);

   assign cmd_ready_o      = !full && !clr_i && !rst_i;
   assign udma_cmd_valid_o = !empty && !head_eot;
   assign udma_cmd_o       = empty ? last_q : head;
   assign eot_o            = eot_q;
   assign fill_o           = wr_ptr_q - rd_ptr_q;
   assign cmd_count_o      = cnt_q;

   assign push    = cmd_valid_i && cmd_ready_o;
   assign fwd_pop = udma_cmd_valid_o && udma_cmd_ready_i && !clr_i;
   assign eot_pop = !empty && head_eot && !clr_i;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      eot_d    = eot_pop;
      last_d   = empty ? last_q : head;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         eot_d    = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q[LOG_DEPTH-1:0]] = cmd_data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (fwd_pop || eot_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (fwd_pop) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         eot_q    <= 1'b0;
         last_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         eot_q    <= eot_d;
         last_q   <= last_d;
      end
   end

endmodule
